// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the scoreboarded register file
interface reg_file_sb_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         WriteEn;
  logic [D-1:0] Waddr;
  logic [W-1:0] DataIn;
  logic [D-1:0] RaddrA;
  logic [D-1:0] RaddrB;
  logic [W-1:0] DataOutA;
  logic [W-1:0] DataOutB;
  logic         HazardA;
  logic         HazardB;
  logic         IssueEn;
  logic [D-1:0] IssueAddr;
  logic         IssueStall;
  logic [D:0]   PendingCount;
  modport master (
    output WriteEn, Waddr, DataIn, RaddrA, RaddrB, IssueEn, IssueAddr,
    input  DataOutA, DataOutB, HazardA, HazardB, IssueStall, PendingCount
  );
  modport slave (
    input  WriteEn, Waddr, DataIn, RaddrA, RaddrB, IssueEn, IssueAddr,
    output DataOutA, DataOutB, HazardA, HazardB, IssueStall, PendingCount
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write bypass and pending-write scoreboard
module reg_file_sb #(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic Clk,
  input logic Reset,
  reg_file_sb_if.slave bus
);
  localparam int N = 1 << D;
  logic [W-1:0] regs [N];
  logic [N-1:0] pending;
  logic [N-1:0] clr;
  logic [N-1:0] set;
  logic [D:0]   count;
  logic         wz;
  logic         iz;
  logic         byp_a;
  logic         byp_b;
  logic         accept;
  logic         inc;
  logic         dec;
  // register 0 swallows writes and issues when hard-wired to zero
  assign wz     = bus.WriteEn && !(ZERO_REG && bus.Waddr == '0);
  assign iz     = bus.IssueEn && !(ZERO_REG && bus.IssueAddr == '0);
  assign byp_a  = BYPASS && wz && bus.Waddr == bus.RaddrA;
  assign byp_b  = BYPASS && wz && bus.Waddr == bus.RaddrB;
  assign bus.DataOutA = byp_a ? bus.DataIn : regs[bus.RaddrA];
  assign bus.DataOutB = byp_b ? bus.DataIn : regs[bus.RaddrB];
  assign bus.HazardA  = pending[bus.RaddrA] && !byp_a;
  assign bus.HazardB  = pending[bus.RaddrB] && !byp_b;
  assign bus.IssueStall = bus.IssueEn && pending[bus.IssueAddr]
                          && !(bus.WriteEn && bus.Waddr == bus.IssueAddr);
  assign bus.PendingCount = count;
  assign accept = iz && !bus.IssueStall;
  assign clr    = wz ? N'(1) << bus.Waddr : '0;
  assign set    = accept ? N'(1) << bus.IssueAddr : '0;
  // a same-address set keeps the bit, so the write must not decrement
  assign inc    = accept && !pending[bus.IssueAddr];
  assign dec    = wz && pending[bus.Waddr] && !(accept && bus.IssueAddr == bus.Waddr);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      pending <= '0;
      count   <= '0;
    end else begin
      if (wz) regs[bus.Waddr] <= bus.DataIn;
      pending <= (pending & ~clr) | set;
      count   <= count + (D+1)'(inc) - (D+1)'(dec);
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector bench for reg_file_sb
module tb_reg_file_sb;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 Clk = ~Clk;
  reg_file_sb_if #(.W(8), .D(3)) b0 ();
  reg_file_sb_if #(.W(8), .D(3)) b1 ();
  reg_file_sb_if #(.W(8), .D(3)) b2 ();
  reg_file_sb_if #(.W(8), .D(2)) b3 ();
  reg_file_sb #(.W(8), .D(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u0 (.Clk(Clk), .Reset(Reset), .bus(b0.slave));
  reg_file_sb #(.W(8), .D(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (.Clk(Clk), .Reset(Reset), .bus(b1.slave));
  reg_file_sb #(.W(8), .D(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u2 (.Clk(Clk), .Reset(Reset), .bus(b2.slave));
  reg_file_sb #(.W(8), .D(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u3 (.Clk(Clk), .Reset(Reset), .bus(b3.slave));
  typedef struct {
    logic we; logic [2:0] wa; logic [7:0] din; logic [2:0] ra; logic [2:0] rb;
    logic ie; logic [2:0] ia;
    logic [7:0] ea; logic [7:0] eb; logic eha; logic ehb; logic est; logic [3:0] ecnt;
  } vec_t;
  vec_t tv [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle1();
    b1.WriteEn = 0; b1.Waddr = 0; b1.DataIn = 0; b1.RaddrA = 0; b1.RaddrB = 0; b1.IssueEn = 0; b1.IssueAddr = 0;
  endtask
  task automatic idle2();
    b2.WriteEn = 0; b2.Waddr = 0; b2.DataIn = 0; b2.RaddrA = 0; b2.RaddrB = 0; b2.IssueEn = 0; b2.IssueAddr = 0;
  endtask
  task automatic idle3();
    b3.WriteEn = 0; b3.Waddr = 0; b3.DataIn = 0; b3.RaddrA = 0; b3.RaddrB = 0; b3.IssueEn = 0; b3.IssueAddr = 0;
  endtask
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{0,0,8'h00,0,0,0,0, 8'h00,8'h00,0,0,0,0};
    tv[1]  = '{1,3,8'h5A,3,0,0,0, 8'h5A,8'h00,0,0,0,0};
    tv[2]  = '{0,0,8'h00,3,0,0,0, 8'h5A,8'h00,0,0,0,0};
    tv[3]  = '{1,5,8'hC3,5,5,0,0, 8'hC3,8'hC3,0,0,0,0};
    tv[4]  = '{0,0,8'h00,5,2,1,2, 8'hC3,8'h00,0,0,0,0};
    tv[5]  = '{0,0,8'h00,5,2,0,0, 8'hC3,8'h00,0,1,0,1};
    tv[6]  = '{1,2,8'h11,5,2,0,0, 8'hC3,8'h11,0,0,0,1};
    tv[7]  = '{0,0,8'h00,5,2,0,0, 8'hC3,8'h11,0,0,0,0};
    tv[8]  = '{0,0,8'h00,4,2,1,4, 8'h00,8'h11,0,0,0,0};
    tv[9]  = '{0,0,8'h00,4,2,1,4, 8'h00,8'h11,1,0,1,1};
    tv[10] = '{1,4,8'h77,4,2,1,4, 8'h77,8'h11,0,0,0,1};
    tv[11] = '{0,0,8'h00,4,2,0,0, 8'h77,8'h11,1,0,0,1};
    tv[12] = '{1,0,8'hFF,0,4,1,0, 8'hFF,8'h77,0,1,0,1};
    tv[13] = '{0,0,8'h00,0,4,0,0, 8'hFF,8'h77,1,1,0,2};
    tv[14] = '{1,4,8'h88,4,0,0,0, 8'h88,8'hFF,0,1,0,2};
    tv[15] = '{1,0,8'h01,0,4,0,0, 8'h01,8'h88,0,0,0,1};
    tv[16] = '{0,0,8'h00,0,4,0,0, 8'h01,8'h88,0,0,0,0};
    tv[17] = '{0,0,8'h00,1,6,1,1, 8'h00,8'h00,0,0,0,0};
    tv[18] = '{1,1,8'h22,1,6,1,6, 8'h22,8'h00,0,0,0,1};
    tv[19] = '{0,0,8'h00,1,6,0,0, 8'h22,8'h00,0,1,0,1};
    b0.WriteEn = 0; b0.Waddr = 0; b0.DataIn = 0; b0.RaddrA = 0; b0.RaddrB = 0; b0.IssueEn = 0; b0.IssueAddr = 0;
    idle1(); idle2(); idle3();
    #3 Reset = 1'b1;
    #1;
    chk("async_reset_cnt", 32'(b0.PendingCount), 0);
    chk("async_reset_a", 32'(b0.DataOutA), 0);
    chk("async_reset_ha", 32'(b0.HazardA), 0);
    #8 Reset = 1'b0;
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      b0.WriteEn = tv[i].we; b0.Waddr = tv[i].wa; b0.DataIn = tv[i].din;
      b0.RaddrA = tv[i].ra; b0.RaddrB = tv[i].rb; b0.IssueEn = tv[i].ie; b0.IssueAddr = tv[i].ia;
      @(negedge Clk);
      chk($sformatf("v%0d_a", i), 32'(b0.DataOutA), 32'(tv[i].ea));
      chk($sformatf("v%0d_b", i), 32'(b0.DataOutB), 32'(tv[i].eb));
      chk($sformatf("v%0d_ha", i), 32'(b0.HazardA), 32'(tv[i].eha));
      chk($sformatf("v%0d_hb", i), 32'(b0.HazardB), 32'(tv[i].ehb));
      chk($sformatf("v%0d_stall", i), 32'(b0.IssueStall), 32'(tv[i].est));
      chk($sformatf("v%0d_cnt", i), 32'(b0.PendingCount), 32'(tv[i].ecnt));
      next_cycle();
    end
    // no bypass: same-cycle write invisible and does not mask hazard
    b1.WriteEn = 1; b1.Waddr = 5; b1.DataIn = 8'hC3; b1.RaddrA = 5; b1.RaddrB = 5;
    @(negedge Clk);
    chk("nobyp_a", 32'(b1.DataOutA), 0);
    chk("nobyp_b", 32'(b1.DataOutB), 0);
    next_cycle();
    idle1(); b1.RaddrA = 5; b1.RaddrB = 5; b1.IssueEn = 1; b1.IssueAddr = 2;
    @(negedge Clk);
    chk("nobyp_a_next", 32'(b1.DataOutA), 32'h C3);
    chk("nobyp_b_next", 32'(b1.DataOutB), 32'h C3);
    next_cycle();
    idle1(); b1.WriteEn = 1; b1.Waddr = 2; b1.DataIn = 8'h11; b1.RaddrB = 2;
    @(negedge Clk);
    chk("nobyp_hb", 32'(b1.HazardB), 1);
    chk("nobyp_b_old", 32'(b1.DataOutB), 0);
    chk("nobyp_cnt", 32'(b1.PendingCount), 1);
    next_cycle();
    idle1(); b1.RaddrB = 2;
    @(negedge Clk);
    chk("nobyp_hb_clr", 32'(b1.HazardB), 0);
    chk("nobyp_b_new", 32'(b1.DataOutB), 32'h11);
    chk("nobyp_cnt_clr", 32'(b1.PendingCount), 0);
    next_cycle();
    // zero register ignores writes and issues
    b2.WriteEn = 1; b2.Waddr = 0; b2.DataIn = 8'hFF; b2.IssueEn = 1; b2.IssueAddr = 0; b2.RaddrA = 0;
    @(negedge Clk);
    chk("z_a", 32'(b2.DataOutA), 0);
    chk("z_ha", 32'(b2.HazardA), 0);
    chk("z_stall", 32'(b2.IssueStall), 0);
    next_cycle();
    b2.WriteEn = 0;
    @(negedge Clk);
    chk("z_a_next", 32'(b2.DataOutA), 0);
    chk("z_ha_next", 32'(b2.HazardA), 0);
    chk("z_stall_again", 32'(b2.IssueStall), 0);
    chk("z_cnt", 32'(b2.PendingCount), 0);
    next_cycle();
    idle2();
    @(negedge Clk);
    chk("z_cnt_final", 32'(b2.PendingCount), 0);
    next_cycle();
    // D=2: fill every register, then reset during a write
    for (int i = 0; i < 4; i++) begin
      b3.IssueEn = 1; b3.IssueAddr = 2'(i);
      next_cycle();
    end
    idle3(); b3.RaddrA = 3; b3.RaddrB = 0;
    @(negedge Clk);
    chk("d2_cnt_full", 32'(b3.PendingCount), 4);
    chk("d2_ha", 32'(b3.HazardA), 1);
    chk("d2_hb", 32'(b3.HazardB), 1);
    next_cycle();
    b3.WriteEn = 1; b3.Waddr = 1; b3.DataIn = 8'hAA; b3.RaddrA = 1; b3.RaddrB = 2;
    b3.IssueEn = 1; b3.IssueAddr = 3;
    #2 Reset = 1'b1;
    #1;
    chk("d2_rst_cnt", 32'(b3.PendingCount), 0);
    chk("d2_rst_hb", 32'(b3.HazardB), 0);
    chk("d2_rst_b", 32'(b3.DataOutB), 0);
    chk("d2_rst_stall", 32'(b3.IssueStall), 0);
    chk("d2_rst_byp", 32'(b3.DataOutA), 32'hAA);
    next_cycle();
    Reset = 1'b0;
    idle3(); b3.RaddrA = 1; b3.RaddrB = 3;
    @(negedge Clk);
    chk("d2_post_a", 32'(b3.DataOutA), 0);
    chk("d2_post_hb", 32'(b3.HazardB), 0);
    chk("d2_post_cnt", 32'(b3.PendingCount), 0);
    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
